// File: rtl/countdown_sequencer.sv
// Sequencer for the two-digit ASCII down-counter: validates and loads a
// preset, issues prescaled decrement strobes, and handles pause, abort and
// expiry reporting.
module countdown_sequencer #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    input  logic [15:0] preset,
    input  logic        cnt_done,
    output logic        cnt_load,
    output logic [15:0] cnt_ascii,
    output logic        cnt_decrement,
    output logic        busy,
    output logic        expired,
    output logic        bad_preset,
    output logic [2:0]  state
);

    localparam int unsigned PRESC_W    = 16;
    localparam int unsigned ASCII_W    = 16;
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICK_DIV - 1);
    localparam logic [ASCII_W-1:0] ASCII_ZERO = 16'h3030;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [ASCII_W-1:0]   ascii_d;
    logic                 load_d;
    logic                 expired_d;
    logic                 bad_d;
    logic                 dec_c;
    logic                 preset_ok;

    // One ASCII decimal digit, '0'..'9'.
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Next-state, prescaler and strobe decode; the strobe is qualified by
    // same-cycle abort/done/pause so it can never fire into a finished count.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ascii_d   = cnt_ascii;
        bad_d     = 1'b0;
        dec_c     = 1'b0;
        preset_ok = is_digit(preset[15:8]) && is_digit(preset[7:0]);

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (start) begin
                    if (preset_ok) begin
                        ascii_d = preset;
                        state_d = ST_LOAD;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                presc_d = '0;
                state_d = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_done) begin
                    state_d = ST_EXPIRED;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    dec_c   = (presc_q == PRESC_MAX);
                    presc_d = dec_c ? '0 : presc_q + 16'd1;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_EXPIRED: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load_d    = (state_d == ST_LOAD);
        expired_d = (state_d == ST_EXPIRED);
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            cnt_ascii  <= ASCII_ZERO;
            cnt_load   <= 1'b0;
            expired    <= 1'b0;
            bad_preset <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_ascii  <= ascii_d;
            cnt_load   <= load_d;
            expired    <= expired_d;
            bad_preset <= bad_d;
        end
    end

    assign cnt_decrement = dec_c;
    assign busy          = (state_q != ST_IDLE);
    assign state         = state_q;

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Controller that sequences the two-digit ASCII down-counter datapath. It validates and loads a host-supplied ASCII preset, then issues prescaled single-cycle decrement strobes until the counter reports done. It supports pause/resume and abort, and reports expiry to the host. It sits between the host/keypad logic and the `counter` instance, and owns that instance's load (`reset`) and `decrement` inputs.

## Interface
- `TICK_DIV`, default 10: clock cycles between successive decrement strobes; legal range 2..65535.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to load `preset` and begin counting; honoured only in IDLE.
- `pause`  in  1: level; while high, RUN holds.
- `abort`  in  1: return to IDLE from any non-IDLE state.
- `preset`  in  16: two ASCII decimal digits; [15:8] is tens, [7:0] is units.
- `cnt_done`  in  1: counter value equals "00".
- `cnt_load`  out  1: drives the counter's load/reset input; the counter loads `cnt_ascii` on a clock edge while this is high.
- `cnt_ascii`  out  16: latched preset presented to the counter.
- `cnt_decrement`  out  1: single-cycle strobe; the counter decrements once per edge while high.
- `busy`  out  1: high in LOAD, RUN, PAUSE and EXPIRED.
- `expired`  out  1: one-cycle pulse when the count completes.
- `bad_preset`  out  1: one-cycle pulse when `start` is rejected.
- `state`  out  3: IDLE=0, LOAD=1, RUN=2, PAUSE=3, EXPIRED=4.

## Operation
- Reset (`reset`=0) forces the following immediately, without waiting for a clock edge:
  - state IDLE, prescaler 0.
  - `cnt_load`, `cnt_decrement`, `busy`, `expired` and `bad_preset` all 0.
  - `cnt_ascii` = 16'h3030.
- All registered outputs are driven from flops; `busy` decodes `state`.
- IDLE, `start`=1:
  - Valid preset (each byte in 8'h30..8'h39): latch it into `cnt_ascii` and go to LOAD.
  - Invalid preset: pulse `bad_preset` in the next cycle and stay in IDLE; `cnt_ascii` is unchanged.
- LOAD: `cnt_load`=1 for exactly one cycle; clear the prescaler; go to RUN.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and then wraps.
  - In the cycle where the prescaler equals TICK_DIV-1, `cnt_decrement`=1.
  - Priority per cycle: `abort` > `cnt_done` > `pause` > decrement tick.
  - `abort`: go to IDLE.
  - `cnt_done`=1: go to EXPIRED and issue no decrement in that cycle.
  - `pause`: go to PAUSE and freeze the prescaler. No strobe is issued in that cycle, even if the prescaler equals TICK_DIV-1.
- PAUSE:
  - `cnt_decrement`=0; prescaler held.
  - `pause`=0: return to RUN and resume from the held prescaler value.
  - `abort` takes priority over release.
- EXPIRED: `expired`=1 for one cycle; unconditionally go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Abort or reset leaves the counter's value untouched; no reload and no `expired` pulse.
- A valid "00" preset is legal: LOAD, then RUN sees `cnt_done`, then EXPIRED, with zero decrements issued.
- The sequencer never issues a decrement while `cnt_done`=1, so the counter never wraps below "00".

## Timing
- Start latency: `start` sampled at edge N, LOAD in cycle N+1, RUN from cycle N+2.
- Decrement timing: with RUN entered in cycle R and no pause, the k-th strobe is high in cycle R + k·TICK_DIV − 1.
- Expiry timing: after the final strobe in cycle D, `cnt_done` is high in cycle D+1, EXPIRED (`expired`=1) is cycle D+2, and IDLE is cycle D+3.
- Pause cost: each cycle spent in PAUSE delays all later strobes by one cycle, plus the one cycle in which `pause` is sampled.
- `bad_preset` appears in the cycle after the rejected `start`.

## Test plan
- Normal count:
  - Stimulus: TICK_DIV=4, preset "03", `start` in cycle 0.
  - Required response:
    - `cnt_load` high in cycle 1.
    - Strobes in cycles 5, 9 and 13.
    - `cnt_done` from cycle 14.
    - `expired` high in cycle 15.
    - `busy` high in cycles 1..15; state IDLE in cycle 16.
- Zero preset:
  - Stimulus: preset "00", `start` in cycle 0.
  - Required response: LOAD in cycle 1, RUN in cycle 2, `expired` in cycle 3, zero strobes.
- Invalid preset:
  - Stimulus: preset "2A", or 16'h2F30, with `start`.
  - Required response: `bad_preset` pulse in cycle 1, state stays IDLE, `cnt_load` never asserted, `cnt_ascii` still 16'h3030.
- Pause:
  - Stimulus: TICK_DIV=4, preset "02", `pause` high in cycles 4..8.
  - Required response: no strobe in cycles 4..9; strobes in cycles 11 and 15; `expired` in cycle 17.
- Abort mid-count:
  - Stimulus: preset "20", `abort` after the first strobe.
  - Required response: IDLE next cycle, no `expired`, counter holds "19".
  - Follow-up: a new `start` with "05" reloads and counts to expiry.
- Asynchronous reset mid-RUN:
  - Stimulus: `reset` low between clock edges while RUN is active.
  - Required response: `cnt_decrement`, `busy` and `state` drop immediately, `cnt_ascii`=16'h3030, and no activity while `reset`=0.
- Simultaneous events:
  - Stimulus: `start` while in RUN; separately, `pause` and `abort` together.
  - Required response: `start` is ignored; `abort` wins.
